pixel_window_filter: RTL and testbench
======================================

# pixel_window_filter

Parametrised K×K binary-image window filter for 1-bit pixel streams, the generalised successor of the 3×3 averaging stage in the filter pipeline. It buffers K-1 lines, forms a K×K window around each centre pixel, and reduces it by a runtime-selected mode: majority/threshold, erode, dilate or pass-through. It sits between the thresholding stage and the blob/centroid stages, and emits window-centre coordinates with each result.

## Interface
- H_ACTIVE, 320: active pixels per line; hcount_in ranges 0..H_ACTIVE-1.
- V_ACTIVE, 240: active lines per frame.
- K, 3: window size; legal values 3 or 5. R = (K-1)/2.
- DEFAULT_THRESH, 5: threshold applied from reset until the first frame-start latch.
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- data_valid_in  input  1  pixel_data_in, hcount_in and vcount_in are valid this cycle.
- pixel_data_in  input  1  binary pixel.
- hcount_in  input  11  column of the input pixel.
- vcount_in  input  10  row of the input pixel.
- mode_in  input  2  0 THRESH, 1 ERODE, 2 DILATE, 3 PASS.
- thresh_in  input  5  ones-count threshold for THRESH mode; values 0..K*K.
- data_valid_out  output  1  result valid.
- pixel_data_out  output  1  filtered pixel.
- hcount_out  output  11  column of the window centre.
- vcount_out  output  10  row of the window centre.

## Operation
- Line buffers and the window shift register advance only when data_valid_in is 1. Idle cycles change no state.
- Window on input (h,v) covers columns h-2R..h and rows v-2R..v. The centre is (h-R, v-R).
- Positions with column < 0 or row < 0 read as 0 (zero padding). Stale line-buffer data from the previous frame is masked by a vcount compare, not cleared.
- A result is emitted only when hcount_in ≥ R and vcount_in ≥ R. As a result, centres in the right R columns and bottom R rows are never emitted.
- Reduction uses ones = popcount of the K×K window. The count width holds K*K (5 bits).
  - THRESH: out = (ones ≥ thresh). thresh = 0 always gives 1; thresh > K*K always gives 0.
  - ERODE: out = (ones == K*K).
  - DILATE: out = (ones ≥ 1).
  - PASS: out = the centre pixel.
- Frame-start latch: mode_in and thresh_in are captured only on a valid beat with hcount_in==0 and vcount_in==0. Changes mid-frame take effect at the next frame.
- Out-of-range inputs (hcount_in ≥ H_ACTIVE or vcount_in ≥ V_ACTIVE) with valid asserted are dropped. They produce no output and cause no buffer write.

## Timing
- Fixed latency of 2 cycles: valid beat at cycle t gives data_valid_out at t+2. Stage 1 updates the window; stage 2 does the popcount, compare and output registers.
- Throughput is one pixel per cycle. There is no backpressure; the downstream stage must accept every valid beat.
- Output coordinates travel in the same 2-stage pipe, so coordinate and pixel are always aligned.
- Reset values: data_valid_out 0, pixel_data_out 0, hcount_out 0, vcount_out 0. Latched mode = THRESH, latched thresh = DEFAULT_THRESH. Window registers are 0.
- Line-buffer RAM is not reset.
- Reset mid-frame: outputs go to reset values immediately. Pipeline contents are discarded. Output resumes correctly from the next frame start; partial rows before then are zero-padded by the vcount mask only if vcount restarts at 0.

## Configuration
- PIXEL_WINDOW_POPCOUNT_EN defined:
  - Adds output port window_count_out [4:0], registered alongside pixel_data_out with the same latency.
  - Its reset value is 0.
  - It carries the ones count for every mode, including PASS.
- Undefined: the port and its register are absent. Filter behaviour is identical.

## Structure
- Shared package pixel_filter_pkg holds:
  - the filter_mode_t enum (THRESH, ERODE, DILATE, PASS);
  - the 11/10-bit hcount/vcount width constants;
  - the max-window constant 25.
- Sub-module line_buffer_nbit (parameters WIDTH=1, DEPTH=H_ACTIVE, LINES=K-1) provides column-aligned taps of the K-1 previous rows plus the current pixel.
- The top level holds the window shift register, padding masks, frame-start latch, reduction and output pipe.

## Test plan
All scenarios use K=3, H_ACTIVE=8, V_ACTIVE=6.
- All-ones frame, THRESH with thresh 9: centre (1,1) out = 1; centre (0,0) out = 0 (padding gives ones = 4); 35 outputs total (7×5), none for columns 7 or row 5.
- Single 1 at (4,3), DILATE: outputs are 1 exactly at centres (3..5, 2..4) within the emitted range; all others 0. ERODE on the same frame gives all 0.
- mode_in switched THRESH→PASS at (3,2) mid-frame: the rest of the frame stays THRESH; the next frame output equals the input shifted to centres.
- Valid gaps: insert 0-3 idle cycles randomly between beats. Output must match a gapless run bit-for-bit, each output arriving exactly 2 cycles after its triggering beat.
- Assert rst_in at (5,2) for 3 cycles, then restart at (0,0). data_valid_out is 0 during reset and 2 cycles after. The second frame output matches the golden model.
- With PIXEL_WINDOW_POPCOUNT_EN, checkerboard input: interior window_count_out alternates 5/4; centre (0,0) reads 2 (top-left input pixel 1).

Source files
------------

// File: rtl/pixel_filter_pkg.sv
// Shared types and constants for the binary pixel window filter family.
package pixel_filter_pkg;

  typedef enum logic [1:0] {
    THRESH = 2'd0,
    ERODE  = 2'd1,
    DILATE = 2'd2,
    PASS   = 2'd3
  } filter_mode_t;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
  localparam int MAX_WIN  = 25;
  localparam int COUNT_W  = 5;

  function automatic logic [COUNT_W-1:0] popcount_win(input logic [MAX_WIN-1:0] bits);
    logic [COUNT_W-1:0] cnt;
    cnt = {COUNT_W{1'b0}};
    for (int i = 0; i < MAX_WIN; i++) begin
      cnt = cnt + {{(COUNT_W-1){1'b0}}, bits[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pixel_window_filter_if.sv
// Pixel stream bus of pixel_window_filter: master is the pixel source, slave is the filter.
// PIXEL_WINDOW_POPCOUNT_EN adds window_count_out.
interface pixel_window_filter_if;
  import pixel_filter_pkg::*;

  logic                data_valid_in;
  logic                pixel_data_in;
  logic [HCOUNT_W-1:0] hcount_in;
  logic [VCOUNT_W-1:0] vcount_in;
  logic [1:0]          mode_in;
  logic [COUNT_W-1:0]  thresh_in;
  logic                data_valid_out;
  logic                pixel_data_out;
  logic [HCOUNT_W-1:0] hcount_out;
  logic [VCOUNT_W-1:0] vcount_out;
`ifdef PIXEL_WINDOW_POPCOUNT_EN
  logic [COUNT_W-1:0]  window_count_out;
`endif

  modport master (
`ifdef PIXEL_WINDOW_POPCOUNT_EN
    input  window_count_out,
`endif
    output data_valid_in, pixel_data_in, hcount_in, vcount_in, mode_in, thresh_in,
    input  data_valid_out, pixel_data_out, hcount_out, vcount_out
  );

  modport slave (
`ifdef PIXEL_WINDOW_POPCOUNT_EN
    output window_count_out,
`endif
    input  data_valid_in, pixel_data_in, hcount_in, vcount_in, mode_in, thresh_in,
    output data_valid_out, pixel_data_out, hcount_out, vcount_out
  );

endinterface

// File: rtl/pixel_window_filter_line_buffer.sv
// line_buffer_nbit: LINES previous rows held per column; taps[0] is the incoming pixel,
// taps[i] is the pixel i rows above at the same column. Storage is not reset.
module line_buffer_nbit #(
  parameter int  WIDTH  = 1,
  parameter int  DEPTH  = 320,
  parameter int  LINES  = 2,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [WIDTH-1:0]            din,
  output logic [LINES:0][WIDTH-1:0]   taps
);

  logic [WIDTH-1:0] mem_r [LINES][DEPTH];

  // Column-aligned read of every stored row plus the live pixel
  always_comb begin
    taps[0] = din;
    for (int i = 1; i <= LINES; i++) begin
      taps[i] = mem_r[i-1][addr];
    end
  end

  // Each accepted pixel pushes its column one row further back
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[0][addr] <= din;
      for (int i = 1; i < LINES; i++) begin
        mem_r[i][addr] <= mem_r[i-1][addr];
      end
    end
  end

endmodule

// File: rtl/pixel_window_filter.sv
// K x K binary window filter (threshold/erode/dilate/pass) with window-centre coordinates.
// Define PIXEL_WINDOW_POPCOUNT_EN to also output the window ones count.
module pixel_window_filter
  import pixel_filter_pkg::*;
#(
  parameter int H_ACTIVE       = 320,
  parameter int V_ACTIVE       = 240,
  parameter int K              = 3,
  parameter int DEFAULT_THRESH = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  pixel_window_filter_if.slave bus
);

  localparam int R      = (K - 1) / 2;
  localparam int KK     = K * K;
  localparam int ADDR_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  logic                in_range_s;
  logic                accept_s;
  logic                frame_start_s;
  logic                emit_s;
  logic [K-1:0][0:0]   taps_s;
  logic [K-1:0][K-1:0] win_r;      // [columns back][rows back]
  logic [K-1:0][K-1:0] win_nxt_s;
  logic [KK-1:0]       win_flat_s;
  logic [COUNT_W-1:0]  ones_s;
  logic                result_s;
  filter_mode_t        mode_r;
  logic [COUNT_W-1:0]  thresh_r;
  logic                s1_valid_r;
  logic [HCOUNT_W-1:0] s1_h_r;
  logic [VCOUNT_W-1:0] s1_v_r;
  logic                valid_out_r;
  logic                pixel_out_r;
  logic [HCOUNT_W-1:0] hcount_out_r;
  logic [VCOUNT_W-1:0] vcount_out_r;

  line_buffer_nbit #(
    .WIDTH (1),
    .DEPTH (H_ACTIVE),
    .LINES (K - 1)
  ) u_line_buffer (
    .clk   (clk_in),
    .wr_en (accept_s),
    .addr  (bus.hcount_in[ADDR_W-1:0]),
    .din   (bus.pixel_data_in),
    .taps  (taps_s)
  );

  // Beat qualification and next window with zero padding on the top and left edges
  always_comb begin
    in_range_s    = (bus.hcount_in < HCOUNT_W'(H_ACTIVE)) && (bus.vcount_in < VCOUNT_W'(V_ACTIVE));
    accept_s      = bus.data_valid_in && in_range_s;
    frame_start_s = accept_s && (bus.hcount_in == {HCOUNT_W{1'b0}}) && (bus.vcount_in == {VCOUNT_W{1'b0}});
    emit_s        = (bus.hcount_in >= HCOUNT_W'(R)) && (bus.vcount_in >= VCOUNT_W'(R));
    win_nxt_s     = win_r;
    if (accept_s) begin
      // Rows above the frame top hold the previous frame's lines; the vcount compare hides them.
      for (int r = 0; r < K; r++) begin
        win_nxt_s[0][r] = (bus.vcount_in >= VCOUNT_W'(r)) ? taps_s[r][0] : 1'b0;
      end
      for (int c = 1; c < K; c++) begin
        for (int r = 0; r < K; r++) begin
          win_nxt_s[c][r] = (bus.hcount_in >= HCOUNT_W'(c)) ? win_r[c-1][r] : 1'b0;
        end
      end
    end else begin
      win_nxt_s = win_r;
    end
  end

  // Stage 1: window shift and centre coordinates
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      win_r      <= {KK{1'b0}};
      s1_valid_r <= 1'b0;
      s1_h_r     <= {HCOUNT_W{1'b0}};
      s1_v_r     <= {VCOUNT_W{1'b0}};
    end else begin
      win_r      <= win_nxt_s;
      s1_valid_r <= accept_s && emit_s;
      if (accept_s) begin
        s1_h_r <= bus.hcount_in - HCOUNT_W'(R);
        s1_v_r <= bus.vcount_in - VCOUNT_W'(R);
      end
    end
  end

  // Mode and threshold only change on the first pixel of a frame
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mode_r   <= THRESH;
      thresh_r <= COUNT_W'(DEFAULT_THRESH);
    end else if (frame_start_s) begin
      mode_r   <= filter_mode_t'(bus.mode_in);
      thresh_r <= bus.thresh_in;
    end
  end

  // Stage 2 reduction of the window
  always_comb begin
    win_flat_s = win_r;
    ones_s     = popcount_win(MAX_WIN'(win_flat_s));
    result_s   = 1'b0;
    case (mode_r)
      THRESH:  result_s = (ones_s >= thresh_r);
      ERODE:   result_s = (ones_s == COUNT_W'(KK));
      DILATE:  result_s = (ones_s != {COUNT_W{1'b0}});
      PASS:    result_s = win_r[R][R];
      default: result_s = 1'b0;
    endcase
  end

  // Stage 2 output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_out_r  <= 1'b0;
      pixel_out_r  <= 1'b0;
      hcount_out_r <= {HCOUNT_W{1'b0}};
      vcount_out_r <= {VCOUNT_W{1'b0}};
    end else begin
      valid_out_r <= s1_valid_r;
      if (s1_valid_r) begin
        pixel_out_r  <= result_s;
        hcount_out_r <= s1_h_r;
        vcount_out_r <= s1_v_r;
      end
    end
  end

`ifdef PIXEL_WINDOW_POPCOUNT_EN
  logic [COUNT_W-1:0] count_out_r;

  // Ones count travels with the filtered pixel
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_out_r <= {COUNT_W{1'b0}};
    end else if (s1_valid_r) begin
      count_out_r <= ones_s;
    end
  end

  assign bus.window_count_out = count_out_r;
`endif

  assign bus.data_valid_out = valid_out_r;
  assign bus.pixel_data_out = pixel_out_r;
  assign bus.hcount_out     = hcount_out_r;
  assign bus.vcount_out     = vcount_out_r;

endmodule

// File: tb/tb_pixel_window_filter.sv
// Directed bench for pixel_window_filter (K=3, 8x6 frames) against a neighbourhood-sum model.
module tb_pixel_window_filter;
  import pixel_filter_pkg::*;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int K  = 3;
  localparam int R  = (K - 1) / 2;
  localparam int DT = 5;

  typedef struct {
    int due;
    int h;
    int v;
    int pix;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_window_filter_if bus();

  pixel_window_filter #(
    .H_ACTIVE       (H),
    .V_ACTIVE       (V),
    .K              (K),
    .DEFAULT_THRESH (DT)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  exp_t q[$];
  exp_t e;
  int   img[V][H];
  int   out_img[V][H];
  int   out_cnt[V][H];
  int   n_out, edge_hits, cyc, n_checks, n_fail, m_mode, m_thresh;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Ones in the KxK neighbourhood of centre (cx,cy), zero outside the image
  function automatic int win_ones(input int cx, input int cy);
    int s;
    s = 0;
    for (int dy = -R; dy <= R; dy++)
      for (int dx = -R; dx <= R; dx++)
        if (cx + dx >= 0 && cy + dy >= 0 && cx + dx < H && cy + dy < V)
          s += img[cy + dy][cx + dx];
    return s;
  endfunction

  function automatic int model_pix(input int mode, input int thr, input int cx, input int cy);
    int ones;
    ones = win_ones(cx, cy);
    case (mode)
      0:       return (ones >= thr) ? 1 : 0;
      1:       return (ones == K * K) ? 1 : 0;
      2:       return (ones >= 1) ? 1 : 0;
      default: return img[cy][cx];
    endcase
  endfunction

  task automatic beat(input int h, input int v, input int p, input int mode, input int thr);
    @(posedge clk); #1;
    bus.data_valid_in = 1'b1;
    bus.pixel_data_in = p[0];
    bus.hcount_in     = 11'(h);
    bus.vcount_in     = 10'(v);
    bus.mode_in       = 2'(mode);
    bus.thresh_in     = 5'(thr);
    if (h < H && v < V) begin
      if (h == 0 && v == 0) begin
        m_mode   = mode;
        m_thresh = thr;
      end
      if (h >= R && v >= R)
        q.push_back('{due: cyc + 2, h: h - R, v: v - R,
                      pix: model_pix(m_mode, m_thresh, h - R, v - R), cnt: win_ones(h - R, v - R)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.data_valid_in = 1'b0;
      bus.pixel_data_in = 1'($urandom_range(0, 1));
      bus.hcount_in     = 11'($urandom_range(0, 3));
      bus.vcount_in     = 10'($urandom_range(0, 3));
    end
  endtask

  // Raster one frame; mode switches to m1 from (3,2) on; stops before beat index stop_at
  task automatic frame(input int m0, input int m1, input int thr, input int gmax, input bit oor, input int stop_at);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        out_img[y][x] = -1;
        out_cnt[y][x] = -1;
      end
    n_out = 0;
    edge_hits = 0;
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h < H; h++) begin
        if (v * H + h >= stop_at) return;
        beat(h, v, img[v][h], (v > 2 || (v == 2 && h >= 3)) ? m1 : m0, thr);
        if (gmax > 0) idle($urandom_range(0, gmax));
      end
      if (oor && v == 2) begin
        beat(H, 2, 1, m1, thr);
        beat(3, V, 1, m1, thr);
      end
    end
    idle(4);
    check("drain_empty", q.size(), 0);
  endtask

  function automatic int out_sum();
    int s;
    s = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if (out_img[y][x] == 1) s++;
    return s;
  endfunction

  // Compare every output cycle against the model queue
  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", int'(bus.data_valid_out), 0);
    end else if (bus.data_valid_out) begin
      n_out++;
      if (q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_cycle", cyc, e.due);
        check("out_h", int'(bus.hcount_out), e.h);
        check("out_v", int'(bus.vcount_out), e.v);
        check("out_pix", int'(bus.pixel_data_out), e.pix);
`ifdef PIXEL_WINDOW_POPCOUNT_EN
        check("out_count", int'(bus.window_count_out), e.cnt);
`endif
      end
      if (int'(bus.hcount_out) < H - R && int'(bus.vcount_out) < V - R) begin
        out_img[bus.vcount_out][bus.hcount_out] = int'(bus.pixel_data_out);
`ifdef PIXEL_WINDOW_POPCOUNT_EN
        out_cnt[bus.vcount_out][bus.hcount_out] = int'(bus.window_count_out);
`endif
      end else begin
        edge_hits++;
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      check("missing_valid", 0, 1);
      q.delete(0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int diffs;
    bus.data_valid_in = 1'b0;
    bus.pixel_data_in = 1'b0;
    bus.hcount_in     = 11'd0;
    bus.vcount_in     = 10'd0;
    bus.mode_in       = 2'd0;
    bus.thresh_in     = 5'd0;
    m_mode   = 0;
    m_thresh = DT;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", int'(bus.data_valid_out), 0);
    check("reset_pixel", int'(bus.pixel_data_out), 0);
    check("reset_hcount", int'(bus.hcount_out), 0);
    check("reset_vcount", int'(bus.vcount_out), 0);
`ifdef PIXEL_WINDOW_POPCOUNT_EN
    check("reset_count", int'(bus.window_count_out), 0);
`endif

    // All ones, THRESH 9
    foreach (img[y, x]) img[y][x] = 1;
    check("model_corner_ones", win_ones(0, 0), 4);
    frame(0, 0, 9, 0, 1'b0, 1000);
    check("ones_centre_1_1", out_img[1][1], 1);
    check("ones_centre_0_0", out_img[0][0], 0);
    check("ones_output_count", n_out, 35);
    check("ones_edge_outputs", edge_hits, 0);

    // Single pixel at (4,3): DILATE then ERODE
    foreach (img[y, x]) img[y][x] = 0;
    img[3][4] = 1;
    check("model_dilate_pin", model_pix(2, 0, 3, 2), 1);
    frame(2, 2, 0, 0, 1'b0, 1000);
    check("dilate_sum", out_sum(), 9);
    check("dilate_3_2", out_img[2][3], 1);
    check("dilate_5_4", out_img[4][5], 1);
    check("dilate_6_4", out_img[4][6], 0);
    frame(1, 1, 0, 0, 1'b0, 1000);
    check("erode_sum", out_sum(), 0);

    // Random image: mid-frame switch to PASS is ignored, dropped out-of-range beats
    foreach (img[y, x]) img[y][x] = $urandom_range(0, 1);
    frame(0, 3, 4, 0, 1'b1, 1000);
    check("midswitch_count", n_out, 35);
    frame(3, 3, 0, 0, 1'b0, 1000);
    diffs = 0;
    for (int y = 0; y < V - R; y++)
      for (int x = 0; x < H - R; x++)
        if (out_img[y][x] != img[y][x]) diffs++;
    check("pass_shift_diffs", diffs, 0);

    // Threshold boundaries with idle gaps
    foreach (img[y, x]) img[y][x] = $urandom_range(0, 1);
    frame(0, 0, 0, 3, 1'b0, 1000);
    check("thresh0_sum", out_sum(), 35);
    foreach (img[y, x]) img[y][x] = 1;
    frame(0, 0, 10, 2, 1'b0, 1000);
    check("thresh10_sum", out_sum(), 0);
    check("thresh10_count", n_out, 35);

    // Reset in the middle of a frame, then a fresh frame
    foreach (img[y, x]) img[y][x] = $urandom_range(0, 1);
    frame(0, 0, 5, 0, 1'b0, 2 * H + 5);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.data_valid_in = 1'b0;
    q.delete();
    m_mode   = 0;
    m_thresh = DT;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_reset_valid", int'(bus.data_valid_out), 0);
    end
    foreach (img[y, x]) img[y][x] = $urandom_range(0, 1);
    frame(2, 2, 0, 1, 1'b0, 1000);
    check("after_reset_count", n_out, 35);

    // Checkerboard with the top-left pixel set
    foreach (img[y, x]) img[y][x] = ((x + y) % 2 == 0) ? 1 : 0;
    frame(0, 0, 5, 0, 1'b0, 1000);
    check("checker_0_0", out_img[0][0], 0);
    check("checker_2_2", out_img[2][2], 1);
    check("checker_3_2", out_img[2][3], 0);
`ifdef PIXEL_WINDOW_POPCOUNT_EN
    check("checker_count_0_0", out_cnt[0][0], 2);
    check("checker_count_2_2", out_cnt[2][2], 5);
    check("checker_count_3_2", out_cnt[2][3], 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
